// File: rtl/pattern_detector_pkg.sv
// Shared constants and helpers for the serial pattern detector.
package pattern_detector_pkg;

  localparam int         PAT_W_DEF   = 4;
  localparam logic [3:0] PAT_RST_DEF = 4'b1101;
  localparam int         CNT_W_DEF   = 8;

  // Width needed for the fill counter, which runs 0..pat_w-1.
  function automatic int fill_w(input int pat_w);
    return $clog2(pat_w);
  endfunction

endpackage

// File: rtl/pattern_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, else increment unless already at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pattern_detector.sv
// Serial bit-pattern detector with programmable pattern, overlap mode,
// combinational (Mealy) and registered (Moore) match outputs and a
// saturating match counter.
module pattern_detector
  import pattern_detector_pkg::*;
#(
  parameter int               PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_RST_DEF),
  parameter int               OVERLAP = 1,
  parameter int               CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             en,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic             cnt_clr,
  output logic             det,
  output logic             det_q,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int         FW       = fill_w(PAT_W);
  localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W - 1);

  logic [PAT_W-1:0] pat_q,  pat_d;
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             det_q_q, det_q_d;

  logic [PAT_W-1:0] window;
  logic             hit;

  // Candidate window: stored history with the incoming bit as newest.
  assign window = {hist_q, in};
  // A match needs a full history and is judged against the current pattern.
  assign hit    = en & (fill_q == FILL_FULL) & (window == pat_q);
  assign det    = hit & ~rst;

  // Next-state for pattern, history and fill; a pattern write restarts fill.
  always_comb begin
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    det_q_d = hit;
    if (en) begin
      if (hit && (OVERLAP == 0)) begin
        fill_d = '0;
      end else begin
        hist_d = window[PAT_W-2:0];
        if (fill_q != FILL_FULL) begin
          fill_d = fill_q + FW'(1);
        end
      end
    end
    if (cfg_we) begin
      pat_d  = cfg_pat;
      fill_d = '0;
    end
  end

  // State register; reset reloads the default pattern and discards history.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= PAT_RST;
      hist_q  <= '0;
      fill_q  <= '0;
      det_q_q <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      det_q_q <= det_q_d;
    end
  end

  assign det_q = det_q_q;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hit),
    .clr (cnt_clr),
    .cnt (match_cnt)
  );

endmodule

// File: tb/tb_pattern_detector.sv
// Scoreboard bench for pattern_detector: two instances (overlapping with a
// 2-bit counter, non-overlapping with an 8-bit counter) share one stimulus
// stream, and a queue-based reference model predicts both.
module tb_pattern_detector;

  logic       clk = 1'b0;
  logic       rst, din, en, cfg_we, cnt_clr;
  logic [3:0] cfg_pat;

  logic       det0, dq0;
  logic [1:0] cnt0;
  logic       det1, dq1;
  logic [7:0] cnt1;

  always #5 clk = ~clk;

  pattern_detector #(.OVERLAP(1), .CNT_W(2)) u_ov (
    .clk(clk), .rst(rst), .in(din), .en(en), .cfg_we(cfg_we),
    .cfg_pat(cfg_pat), .cnt_clr(cnt_clr),
    .det(det0), .det_q(dq0), .match_cnt(cnt0));

  pattern_detector #(.OVERLAP(0), .CNT_W(8)) u_no (
    .clk(clk), .rst(rst), .in(din), .en(en), .cfg_we(cfg_we),
    .cfg_pat(cfg_pat), .cnt_clr(cnt_clr),
    .det(det1), .det_q(dq1), .match_cnt(cnt1));

  typedef struct {
    logic       d0, q0;
    logic [1:0] c0;
    logic       d1, q1;
    logic [7:0] c1;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  bit   drv_done = 0;

  // Reference model: valid bits seen since the last restart, plus outputs.
  bit         s0[$];
  bit         s1[$];
  logic [3:0] mpat;
  logic       m_dq0, m_dq1;
  int         m_c0, m_c1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // True when the last three stored bits followed by b spell pattern p.
  function automatic bit seq_hit(input bit s[$], input bit b, input logic [3:0] p);
    int v;
    v = 0;
    if (s.size() < 3) return 1'b0;
    for (int k = s.size() - 3; k < s.size(); k++) v = v * 2 + int'(s[k]);
    v = v * 2 + int'(b);
    return (v == int'(p));
  endfunction

  function automatic void model_reset();
    s0.delete();
    s1.delete();
    mpat  = 4'b1101;
    m_dq0 = 1'b0;
    m_dq1 = 1'b0;
    m_c0  = 0;
    m_c1  = 0;
  endfunction

  // One clock: drive inputs, push prediction, advance model, step past edge.
  task automatic cyc(input bit r, input bit e, input bit i, input bit w,
                     input logic [3:0] cp, input bit c);
    exp_t x;
    bit   h0, h1;
    rst = r; en = e; din = i; cfg_we = w; cfg_pat = cp; cnt_clr = c;
    h0 = !r && e && seq_hit(s0, i, mpat);
    h1 = !r && e && seq_hit(s1, i, mpat);
    x.d0 = h0;  x.q0 = m_dq0; x.c0 = 2'(m_c0);
    x.d1 = h1;  x.q1 = m_dq1; x.c1 = 8'(m_c1);
    sb.push_back(x);
    if (r) begin
      model_reset();
    end else begin
      m_dq0 = h0;
      m_dq1 = h1;
      m_c0  = c ? 0 : ((h0 && m_c0 < 3)   ? m_c0 + 1 : m_c0);
      m_c1  = c ? 0 : ((h1 && m_c1 < 255) ? m_c1 + 1 : m_c1);
      if (e) begin
        s0.push_back(i);
        if (s0.size() > 3) void'(s0.pop_front());
        if (h1) s1.delete();
        else begin
          s1.push_back(i);
          if (s1.size() > 3) void'(s1.pop_front());
        end
      end
      if (w) begin
        mpat = cp;
        s0.delete();
        s1.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic bits(input logic [15:0] v, input int n);
    logic [15:0] t;
    t = v;
    for (int k = n - 1; k >= 0; k--) cyc(0, 1, t[k], 0, 4'h0, 0);
  endtask

  // Monitor: compare every presented cycle against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("det_ov",   {7'b0, det0}, {7'b0, e.d0});
        chk("detq_ov",  {7'b0, dq0},  {7'b0, e.q0});
        chk("cnt_ov",   {6'b0, cnt0}, {6'b0, e.c0});
        chk("det_no",   {7'b0, det1}, {7'b0, e.d1});
        chk("detq_no",  {7'b0, dq1},  {7'b0, e.q1});
        chk("cnt_no",   cnt1,         e.c1);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b0; din = 1'b0; cfg_we = 1'b0; cfg_pat = 4'h0; cnt_clr = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // Stream 1101101: overlap hits on bits 4 and 7, non-overlap on bit 4 only.
    bits(16'b1101101, 7);
    cyc(0, 0, 0, 0, 4'h0, 0);
    chk("stream_cnt_ov", {6'b0, cnt0}, 8'd2);
    chk("stream_cnt_no", cnt1, 8'd1);

    // en gap with in toggling between bits 3 and 4.
    cyc(1, 0, 0, 0, 4'h0, 0);
    bits(16'b110, 3);
    cyc(0, 0, 1, 0, 4'h0, 0);
    cyc(0, 0, 0, 0, 4'h0, 0);
    cyc(0, 0, 1, 0, 4'h0, 0);
    rst = 0; en = 1; din = 1; cfg_we = 0; cnt_clr = 0;
    #1;
    chk("gap_det", {6'b0, det1, det0}, 8'b11);
    cyc(0, 1, 1, 0, 4'h0, 0);

    // Saturation on the 2-bit counter, then clear beats a simultaneous hit.
    cyc(1, 0, 0, 0, 4'h0, 0);
    bits(16'b1101, 4);
    for (int k = 0; k < 4; k++) bits(16'b101, 3);
    chk("sat_cnt", {6'b0, cnt0}, 8'd3);
    bits(16'b10, 2);
    cyc(0, 1, 1, 0, 4'h0, 1);
    chk("clr_cnt", {6'b0, cnt0}, 8'd0);

    // Pattern write on the completing bit, then new pattern 0110.
    cyc(1, 0, 0, 0, 4'h0, 0);
    bits(16'b110, 3);
    cyc(0, 1, 1, 1, 4'b0110, 0);
    chk("cfg_detq", {6'b0, dq1, dq0}, 8'b11);
    bits(16'b0110, 4);
    bits(16'b1101, 4);

    // Reset mid-pattern discards history.
    bits(16'b110, 3);
    cyc(1, 1, 0, 0, 4'h0, 0);
    chk("rst_outs", {dq1, cnt1[6:0]} | {dq0, 5'b0, cnt0}, 8'd0);
    cyc(0, 1, 1, 0, 4'h0, 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
          1'($urandom), ($urandom_range(0, 39) == 0), 4'($urandom),
          ($urandom_range(0, 29) == 0));
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
